// File: rtl/program_loader.sv
// Byte-stream instruction loader: assembles big-endian 24-bit words from a
// valid/ready byte link and writes them to instruction memory from address 0.
module program_loader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 3
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    core_reset,
  output logic                    busy,
  output logic                    done
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_B2    = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               in_ready_q, mem_we_q, busy_q, done_q, core_reset_q;
  logic               xfer;

  assign xfer = in_valid & in_ready_q;

  // Next-state, word assembly and address/length bookkeeping.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
        else       state_d = S_IDLE;
      end
      S_LEN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          // A zero length byte means a full-memory load.
          remaining_d = (in_data == 8'd0) ? FULL_DEPTH : CNT_W'(in_data);
          addr_d      = {ADDR_W{1'b0}};
          state_d     = S_B0;
        end else begin
          state_d = S_LEN;
        end
      end
      S_B0: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wdata_d[WORD_W-1 -: 8] = in_data;
          state_d                = S_B1;
        end else begin
          state_d = S_B0;
        end
      end
      S_B1: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wdata_d[WORD_W-9 -: 8] = in_data;
          state_d                = S_B2;
        end else begin
          state_d = S_B1;
        end
      end
      S_B2: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wdata_d[7:0] = in_data;
          state_d      = S_WRITE;
        end else begin
          state_d = S_B2;
        end
      end
      S_WRITE: begin
        // The write in this cycle always lands, even if aborted.
        addr_d      = addr_q + ADDR_ONE;
        remaining_d = remaining_q - CNT_ONE;
        if (abort)                       state_d = S_IDLE;
        else if (remaining_q == CNT_ONE) state_d = S_DONE;
        else                             state_d = S_B0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are decoded from the next state.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= {CNT_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {WORD_W{1'b0}};
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      in_ready_q   <= (state_d == S_LEN) || (state_d == S_B0) ||
                      (state_d == S_B1)  || (state_d == S_B2);
      mem_we_q     <= (state_d == S_WRITE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      core_reset_q <= (state_d != S_IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign core_reset = core_reset_q;

endmodule
